muldiv_unit: RTL and testbench

//  Iterative multiply/divide engine in the execute stage, one stage upstream of memory.

---
 rtl/muldiv_unit_pkg.sv | 94 +++++++++
 rtl/muldiv_fsm.sv | 91 +++++++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiply).
package muldiv_unit_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] u64;
  typedef logic [31:0]     word_t;

  typedef enum logic [3:0] {
    MD_MUL    = 4'd0,
    MD_MULH   = 4'd1,
    MD_MULHSU = 4'd2,
    MD_MULHU  = 4'd3,
    MD_DIV    = 4'd4,
    MD_DIVU   = 4'd5,
    MD_REM    = 4'd6,
    MD_REMU   = 4'd7,
    MD_MULW   = 4'd8,
    MD_DIVW   = 4'd9,
    MD_DIVUW  = 4'd10,
    MD_REMW   = 4'd11,
    MD_REMUW  = 4'd12
  } muldiv_op_t;

  function automatic logic is_div(input muldiv_op_t op);
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU,
      MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: is_div = 1'b1;
      default:                              is_div = 1'b0;
    endcase
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    case (op)
      MD_REM, MD_REMU, MD_REMW, MD_REMUW: is_rem = 1'b1;
      default:                            is_rem = 1'b0;
    endcase
  endfunction

  function automatic logic is_word(input muldiv_op_t op);
    case (op)
      MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: is_word = 1'b1;
      default:                                       is_word = 1'b0;
    endcase
  endfunction

  function automatic logic is_mul_hi(input muldiv_op_t op);
    case (op)
      MD_MULH, MD_MULHSU, MD_MULHU: is_mul_hi = 1'b1;
      default:                      is_mul_hi = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_a(input muldiv_op_t op);
    case (op)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM,
      MD_MULW, MD_DIVW, MD_REMW: is_signed_a = 1'b1;
      default:                   is_signed_a = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM,
      MD_MULW, MD_DIVW, MD_REMW: is_signed_b = 1'b1;
      default:                   is_signed_b = 1'b0;
    endcase
  endfunction

  function automatic u64 sext32(input word_t v);
    sext32 = {{32{v[31]}}, v};
  endfunction

  // Select the architectural result from a magnitude product; neg restores the sign.
  function automatic u64 mul_select(input muldiv_op_t op, input logic [2*XLEN-1:0] prod,
                                    input logic neg);
    logic [2*XLEN-1:0] p;
    u64                r;
    p = neg ? (~prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod;
    if (is_mul_hi(op)) begin
      r = p[2*XLEN-1:XLEN];
    end else begin
      r = p[XLEN-1:0];
    end
    if (is_word(op)) begin
      r = sext32(r[31:0]);
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Control FSM for muldiv_unit: IDLE/BUSY/DONE sequencing, iteration counter,
// registered ready/busy/done flags.
module muldiv_fsm
  import muldiv_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic accept,
  input  logic direct,
  input  logic word,
  output logic ready,
  output logic busy,
  output logic done,
  output logic step,
  output logic last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_r;
  logic [1:0] base_nxt_s;
  logic [1:0] state_nxt_s;
  logic [5:0] count_r;
  logic [5:0] limit_s;
  logic       word_r;
  logic       ready_r;
  logic       busy_r;
  logic       done_r;

  assign limit_s = word_r ? 6'd31 : 6'd63;
  assign step    = (state_r == S_BUSY);
  assign last    = step && (count_r == limit_s);
  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // Next-state decode; a flush overrides every transition.
  always_comb begin
    base_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (accept) begin
          base_nxt_s = direct ? S_DONE : S_BUSY;
        end else begin
          base_nxt_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (count_r == limit_s) begin
          base_nxt_s = S_DONE;
        end else begin
          base_nxt_s = S_BUSY;
        end
      end
      S_DONE:  base_nxt_s = S_IDLE;
      default: base_nxt_s = S_IDLE;
    endcase
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      state_nxt_s = base_nxt_s;
    end
  end

  // State, counter and status flags, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      count_r <= 6'd0;
      word_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == S_IDLE);
      busy_r  <= (state_nxt_s != S_IDLE);
      done_r  <= (state_nxt_s == S_DONE);
      if (accept) begin
        count_r <= 6'd0;
        word_r  <= word;
      end else if (step) begin
        count_r <= count_r + 6'd1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV64M iterative multiply/divide engine (radix-2 shift-add multiply,
// restoring divide). Build macro MULDIV_FAST_MUL_EN switches all MUL* ops
// to a single-cycle multiplier; the divide path is unaffected.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  muldiv_op_t op_s, op_r;
  logic word_s, sa_s, sb_s, div_s, a_neg_s, b_neg_s;
  logic b_zero_s, ovf_s, special_s, direct_s, accept_s;
  logic ready_s, step_s, last_s;
  logic a_neg_r, b_neg_r;
  u64   a_op_s, b_op_s, abs_a_s, abs_b_s, min_s;
  u64   special_res_s, direct_res_s;
  u64   mcand_r, hi_r, lo_r, result_r;
  logic [XLEN:0]     add_s, rem_sh_s, diff_s;
  u64                step_hi_s, step_lo_s, quo_s, rem_s, final_res_s;
  logic [2*XLEN-1:0] prod_s;

  assign op_s     = muldiv_op_t'(op_i);
  assign accept_s = valid_i & ready_s & ~flush_i;
  assign ready_o  = ready_s;
  assign result_o = result_r;

  muldiv_fsm u_fsm (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush_i),
    .accept (accept_s),
    .direct (direct_s),
    .word   (word_s),
    .ready  (ready_s),
    .busy   (busy_o),
    .done   (done_o),
    .step   (step_s),
    .last   (last_s)
  );

  // Operand conditioning: W extension, magnitudes and divide special cases.
  always_comb begin
    word_s = is_word(op_s);
    sa_s   = is_signed_a(op_s);
    sb_s   = is_signed_b(op_s);
    div_s  = is_div(op_s);
    if (word_s) begin
      a_op_s = sa_s ? sext32(a_i[31:0]) : {32'd0, a_i[31:0]};
      b_op_s = sb_s ? sext32(b_i[31:0]) : {32'd0, b_i[31:0]};
      min_s  = 64'hFFFF_FFFF_8000_0000;
    end else begin
      a_op_s = a_i;
      b_op_s = b_i;
      min_s  = 64'h8000_0000_0000_0000;
    end
    a_neg_s   = sa_s & a_op_s[XLEN-1];
    b_neg_s   = sb_s & b_op_s[XLEN-1];
    abs_a_s   = a_neg_s ? (~a_op_s + 64'd1) : a_op_s;
    abs_b_s   = b_neg_s ? (~b_op_s + 64'd1) : b_op_s;
    b_zero_s  = (b_op_s == 64'd0);
    ovf_s     = sa_s & (a_op_s == min_s) & (b_op_s == {XLEN{1'b1}});
    special_s = div_s & (b_zero_s | ovf_s);
    if (is_rem(op_s)) begin
      special_res_s = b_zero_s ? a_op_s : 64'd0;
    end else begin
      special_res_s = b_zero_s ? {XLEN{1'b1}} : a_op_s;
    end
    if (word_s) begin
      special_res_s = sext32(special_res_s[31:0]);
    end else begin
      special_res_s = special_res_s;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
  assign fast_prod_s  = {{XLEN{1'b0}}, abs_a_s} * {{XLEN{1'b0}}, abs_b_s};
  assign direct_s     = special_s | ~div_s;
  assign direct_res_s = special_s ? special_res_s
                                  : mul_select(op_s, fast_prod_s, a_neg_s ^ b_neg_s);
`else
  assign direct_s     = special_s;
  assign direct_res_s = special_res_s;
`endif

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    add_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
    rem_sh_s = {hi_r, lo_r[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, mcand_r};
    if (is_div(op_r)) begin
      if (!diff_s[XLEN]) begin
        step_hi_s = diff_s[XLEN-1:0];
        step_lo_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        step_hi_s = rem_sh_s[XLEN-1:0];
        step_lo_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi_s = add_s[XLEN:1];
      step_lo_s = {add_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Final result from the last iteration: sign fix-up and W extension.
  always_comb begin
    prod_s = {step_hi_s, step_lo_s};
    if (is_word(op_r)) begin
      // Only 32 multiply steps ran, so the product sits 32 bits high.
      prod_s = prod_s >> 7'd32;
    end else begin
      prod_s = prod_s;
    end
    quo_s = (a_neg_r ^ b_neg_r) ? (~step_lo_s + 64'd1) : step_lo_s;
    rem_s = a_neg_r ? (~step_hi_s + 64'd1) : step_hi_s;
    if (is_div(op_r)) begin
      final_res_s = is_rem(op_r) ? rem_s : quo_s;
      if (is_word(op_r)) begin
        final_res_s = sext32(final_res_s[31:0]);
      end else begin
        final_res_s = final_res_s;
      end
    end else begin
      final_res_s = mul_select(op_r, prod_s, a_neg_r ^ b_neg_r);
    end
  end

  // Datapath registers: load on accept, iterate while busy, publish at the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= MD_MUL;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      mcand_r  <= 64'd0;
      hi_r     <= 64'd0;
      lo_r     <= 64'd0;
      result_r <= 64'd0;
    end else if (accept_s) begin
      op_r    <= op_s;
      a_neg_r <= a_neg_s;
      b_neg_r <= b_neg_s;
      hi_r    <= 64'd0;
      if (div_s) begin
        mcand_r <= abs_b_s;
        // W dividends start at the top so the 32 steps consume them MSB first.
        lo_r    <= word_s ? {abs_a_s[31:0], 32'd0} : abs_a_s;
      end else begin
        mcand_r <= abs_a_s;
        lo_r    <= abs_b_s;
      end
      if (direct_s) begin
        result_r <= direct_res_s;
      end
    end else if (step_s && !flush_i) begin
      hi_r <= step_hi_s;
      lo_r <= step_lo_s;
      if (last_s) begin
        result_r <= final_res_s;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: expected result and latency are queued
// when an op is driven and checked when done_o pulses.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [63:0] a_i = 64'd0;
  logic [63:0] b_i = 64'd0;
  logic        ready_o, busy_o, done_o;
  logic [63:0] result_o;

  typedef struct packed {
    logic [63:0] res;
    logic [31:0] lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [63:0] last_res = 64'd0;
  localparam logic [63:0] ONES = {64{1'b1}};

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input logic word);
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return word ? 33 : 65;
`endif
  endfunction

  // Monitor: timestamps accepts and scores every done_o pulse mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("result", result_o, mon_e.res);
          check_eq("latency", 64'(cyc - acc_cyc), 64'(mon_e.lat));
        end
      end
      if (valid_i && ready_o && !flush_i) acc_cyc = cyc;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input bit push, input bit wt);
    int   n = 0;
    exp_t e;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) check_eq("ready_timeout", 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    if (push) begin
      e.res = exp;
      e.lat = 32'(lat);
      exp_q.push_back(e);
      last_res = exp;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (wt) wait_idle();
  endtask

  initial begin
    logic [63:0] ra, rb;
    // Reset state
    @(posedge clk); #1;
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed multiply cases
    issue(MD_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, mul_lat(1'b0), 1, 1);
    issue(MD_MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, mul_lat(1'b0), 1, 1);
    issue(MD_MULH,   ONES, ONES, 64'd0, mul_lat(1'b0), 1, 1);
    issue(MD_MULHSU, ONES, 64'd2, ONES, mul_lat(1'b0), 1, 1);
    issue(MD_MULW,   64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFFA, mul_lat(1'b1), 1, 1);

    // Directed divide cases
    issue(MD_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1, 1);
    issue(MD_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1, 1);
    issue(MD_DIVW,  64'h0000_0001_0000_0008, 64'd2, 64'd4, 33, 1, 1);
    issue(MD_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 33, 1, 1);
    issue(MD_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 1, 1);
    issue(MD_DIVU,  64'd100, 64'd7, 64'd14, 65, 1, 1);
    issue(MD_REMU,  64'd100, 64'd7, 64'd2, 65, 1, 1);

    // Special cases complete in cycle 1
    issue(MD_DIVU, 64'd5, 64'd0, ONES, 1, 1, 1);
    issue(MD_REM,  64'h8000_0000_0000_0000, ONES, 64'd0, 1, 1, 1);
    issue(MD_DIV,  64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, 1, 1);
    issue(MD_DIVW, 64'h0000_0000_8000_0001, 64'd0, ONES, 1, 1, 1);
    issue(MD_REMW, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
          64'hFFFF_FFFF_8000_0001, 1, 1, 1);
    issue(MD_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, 1, 1);

    // Flush at cycle 10 of a DIV: no done, result held, next op fine
    issue(MD_DIV, 64'd100, 64'd7, 64'd0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    check_eq("busy_mid_div", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check_eq("flush_ready", 64'(ready_o), 64'd1);
    check_eq("flush_busy", 64'(busy_o), 64'd0);
    check_eq("flush_result_held", result_o, last_res);
    repeat (70) @(posedge clk);
    #1;
    issue(MD_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1, 1);

    // Flush and valid in the same cycle: nothing accepted
    valid_i = 1'b1; flush_i = 1'b1; op_i = MD_DIVU; a_i = 64'd9; b_i = 64'd3;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check_eq("flush_valid_busy", 64'(busy_o), 64'd0);
    repeat (5) @(posedge clk);
    #1;

    // valid_i held through BUSY with changing operands: only the first op runs
    valid_i = 1'b1; op_i = MD_DIVU; a_i = 64'd50; b_i = 64'd5;
    mon_e.res = 64'd10; mon_e.lat = 32'd65;
    exp_q.push_back(mon_e);
    @(posedge clk); #1;
    a_i = 64'd77;
    repeat (30) @(posedge clk);
    #1 valid_i = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check_eq("hold_valid_idle", 64'(busy_o), 64'd0);

    // Random unsigned operands against a reference model
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {32'($urandom_range(0, 3)), $urandom} | 64'd1;
      issue(MD_DIVU, ra, rb, ra / rb, 65, 1, 1);
      issue(MD_REMU, ra, rb, ra % rb, 65, 1, 1);
      issue(MD_MUL, ra, rb, ra * rb, mul_lat(1'b0), 1, 1);
      issue(MD_MULHU, ra, rb, 64'(({64'd0, ra} * {64'd0, rb}) >> 64), mul_lat(1'b0), 1, 1);
    end

    // Reset mid-operation: immediate idle, registers cleared
    issue(MD_DIV, 64'd1000, 64'd3, 64'd0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_ready", 64'(ready_o), 64'd1);
    check_eq("midrst_busy", 64'(busy_o), 64'd0);
    check_eq("midrst_done", 64'(done_o), 64'd0);
    check_eq("midrst_result", result_o, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(MD_MUL, 64'd6, 64'd7, 64'd42, mul_lat(1'b0), 1, 1);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
